// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Writer side of the core's instruction memory. A byte stream carrying a
//   one-byte word count N followed by N little-endian 32-bit words is packed
//   and written into instruction memory one word at a time. The core is held
//   in reset until the whole image has been written.
//
// Ports
//   clk         core clock (only domain)
//   reset       synchronous, active-high
//   start       one-cycle pulse; begins a load from IDLE, DONE or ERR
//   rx_data     stream byte
//   rx_valid    rx_data valid
//   rx_ready    loader accepts a byte this cycle
//   imem_we     instruction memory write strobe (one cycle per word)
//   imem_addr   word index being written
//   imem_wdata  assembled instruction word
//   core_reset  core reset, high = core held in reset (registered)
//   busy        load in progress (HDR, DATA, WRITE)
//   done        load completed, core released
//   err         header announced more words than the memory holds
//   word_count  words written in the current or last load
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for start, core held in reset
// HDR   | waiting for the word-count byte N
// DATA  | collecting the four bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// DONE  | image loaded, core running; start begins a new load
// ERR   | bad header, core held in reset; start begins a new load
module imem_boot_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_cnt;
    logic [31:0]       word;
    logic              core_reset_q;
    logic              accept;

    assign accept = rx_valid && rx_ready;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_HDR;
            S_HDR: begin
                if (accept) begin
                    if (rx_data == 8'd0)         state_next = S_DONE;
                    else if (rx_data > DEPTH_B)  state_next = S_ERR;
                    else                         state_next = S_DATA;
                end
            end
            S_DATA:  if (accept && byte_cnt == 2'd3) state_next = S_WRITE;
            S_WRITE: begin
                if (word_cnt + ONE == n_words) state_next = S_DONE;
                else                           state_next = S_DATA;
            end
            S_DONE:  if (start) state_next = S_HDR;
            S_ERR:   if (start) state_next = S_HDR;
            default: state_next = S_IDLE;
        endcase
    end

    // output decode
    always_comb begin
        rx_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            S_HDR:   begin rx_ready = 1'b1; busy = 1'b1; end
            S_DATA:  begin rx_ready = 1'b1; busy = 1'b1; end
            S_WRITE: begin imem_we  = 1'b1; busy = 1'b1; end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The word counter doubles as the write index because both
    // start at zero for every load and advance together on each WRITE.
    // core_reset is computed from the next state so it drops in the very
    // first DONE cycle and comes straight out of a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt     <= 2'd0;
            n_words      <= '0;
            word_cnt     <= '0;
            word         <= 32'd0;
            core_reset_q <= 1'b1;
        end else begin
            core_reset_q <= (state_next != S_DONE);
            if (start && (state == S_IDLE || state == S_DONE || state == S_ERR))
                word_cnt <= '0;
            if (state == S_HDR && accept) begin
                byte_cnt <= 2'd0;
                word_cnt <= '0;
                if (rx_data <= DEPTH_B)
                    n_words <= rx_data[ADDR_W:0];
            end
            if (state == S_DATA && accept) begin
                word[{byte_cnt, 3'b000} +: 8] <= rx_data;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == S_WRITE)
                word_cnt <= word_cnt + ONE;
        end
    end

    assign imem_addr  = word_cnt[ADDR_W-1:0];
    assign imem_wdata = word;
    assign core_reset = core_reset_q;
    assign word_count = word_cnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Scoreboard bench for imem_boot_loader. Each load's expected memory writes
//   are derived from the byte stream (header N, then N little-endian words)
//   and queued; a monitor pops and compares on every imem_we.
//
// Ports: none (top-level bench).
module tb_imem_boot_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // monitor: compare every memory write against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                chk("rx_ready_in_write", {31'b0, rx_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write_addr", {26'b0, imem_addr}, {26'b0, mon_e.addr});
                    chk("write_data", imem_wdata, mon_e.data);
                end
            end
            // core is released exactly while DONE holds
            chk("core_reset_vs_done", {31'b0, core_reset}, {31'b0, !done});
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        chk("rst_rx_ready",   {31'b0, rx_ready},   32'd0);
        chk("rst_imem_we",    {31'b0, imem_we},    32'd0);
        chk("rst_imem_addr",  {26'b0, imem_addr},  32'd0);
        chk("rst_imem_wdata", imem_wdata,          32'd0);
        chk("rst_core_reset", {31'b0, core_reset}, 32'd1);
        chk("rst_busy",       {31'b0, busy},       32'd0);
        chk("rst_done",       {31'b0, done},       32'd0);
        chk("rst_err",        {31'b0, err},        32'd0);
        chk("rst_word_count", {25'b0, word_count}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // mode 0: always valid, 1: valid toggles each cycle, 2: random valid + stray starts
    task automatic send_bytes(input bq_t b, input int mode);
        int idx = 0;
        int cyc = 0;
        bit ph = 1'b1;
        logic v;
        while (idx < b.size()) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ph;
                default: v = 1'($urandom_range(0, 1));
            endcase
            ph = ~ph;
            start = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
            rx_valid = v;
            rx_data = v ? b[idx] : 8'($urandom);
            if (v && rx_ready) idx++;
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: sent %0d of %0d bytes", idx, b.size());
                break;
            end
        end
        rx_valid = 1'b0;
        start = 1'b0;
    endtask

    function automatic bq_t make_load(input int n);
        bq_t b;
        b.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    // reference model: header N, then word i = bytes 1+4i..4+4i little-endian
    task automatic run_load(input bq_t b, input int mode);
        int n;
        bq_t hdr;
        wr_t w;
        n = int'(b[0]);
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                w.addr = ADDR_W'(i);
                w.data = {b[4*i+4], b[4*i+3], b[4*i+2], b[4*i+1]};
                exp_q.push_back(w);
            end
        end
        pulse_start();
        if (n == 0 || n > DEPTH) begin
            hdr.push_back(b[0]);
            send_bytes(hdr, mode);
            if (n == 0) begin
                chk("hdr0_done",       {31'b0, done},       32'd1);
                chk("hdr0_word_count", {25'b0, word_count}, 32'd0);
                chk("hdr0_core_reset", {31'b0, core_reset}, 32'd0);
            end else begin
                chk("bad_hdr_err",        {31'b0, err},        32'd1);
                chk("bad_hdr_core_reset", {31'b0, core_reset}, 32'd1);
                repeat (3) @(negedge clk);
                chk("bad_hdr_err_hold",   {31'b0, err},        32'd1);
                chk("bad_hdr_rx_ready",   {31'b0, rx_ready},   32'd0);
            end
        end else begin
            send_bytes(b, mode);
            chk("last_word_write", {31'b0, imem_we}, 32'd1);
            @(negedge clk);
            chk("load_done",       {31'b0, done},       32'd1);
            chk("load_word_count", {25'b0, word_count}, 32'(n));
            chk("load_core_reset", {31'b0, core_reset}, 32'd0);
            chk("load_all_written", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        bq_t s;
        bq_t part;
        do_reset();

        // basic two-word image, then same with toggling valid
        s = '{8'h02, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        run_load(s, 0);
        run_load(s, 1);

        // oversized header, then recovery
        s = '{8'h41};
        run_load(s, 0);
        run_load(make_load(1), 0);

        // empty image
        s = '{8'h00};
        run_load(s, 0);

        // reset in the middle of the first word
        part = '{8'h03, 8'h11, 8'h22};
        pulse_start();
        send_bytes(part, 0);
        do_reset();
        run_load(make_load(3), 2);

        // full-depth image, then bytes offered after DONE must be refused
        run_load(make_load(DEPTH), 0);
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data = 8'($urandom);
            chk("after_done_rx_ready", {31'b0, rx_ready}, 32'd0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("after_done_word_count", {25'b0, word_count}, 32'(DEPTH));

        // random images with random valid gaps and stray starts
        for (int k = 0; k < 4; k++)
            run_load(make_load(int'($urandom_range(1, 8))), 2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
